ctv_unshift: RTL and testbench

Return-path re-alignment stage for the layered QC-LDPC decoder. Each forward cyclic shift issued toward the check-node units records its shift value in this block. The block holds those values in an in-order FIFO. When the check-node results come back, it applies the inverse rotation (left by `shift` lanes), restoring variable-node lane order. Null submatrices (shift all-ones) return an all-zero message, and the block registers the result behind a valid/ready handshake.

---
 rtl/ctv_unshift_if.sv | 31 +++
 rtl/ctv_unshift.sv | 121 ++++++++++++
 tb/tb_ctv_unshift.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ctv_unshift_if.sv
// rtl/ctv_unshift_if.sv - forward-shift, return-beat and output handshake bundle for ctv_unshift
interface ctv_unshift_if #(
    parameter int data_w = 8,
    parameter int D      = 5,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  fwd_valid;
    logic [data_w-1:0]     fwd_shift;
    logic                  fwd_ready;
    logic                  ret_valid;
    logic [data_w*D-1:0]   ret_ctv;
    logic                  ret_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_w*D-1:0]   out_v;
    logic                  out_null;
    logic [LW-1:0]         level;
    logic                  err_shift;

    modport slave (
        input  fwd_valid, fwd_shift, ret_valid, ret_ctv, out_ready,
        output fwd_ready, ret_ready, out_valid, out_v, out_null, level, err_shift
    );

    modport master (
        output fwd_valid, fwd_shift, ret_valid, ret_ctv, out_ready,
        input  fwd_ready, ret_ready, out_valid, out_v, out_null, level, err_shift
    );
endinterface

// File: rtl/ctv_unshift.sv
// rtl/ctv_unshift.sv - shift-value FIFO plus inverse lane rotation on the check-to-variable return path
module ctv_unshift #(
    parameter int data_w = 8,
    parameter int D      = 5,
    parameter int DEPTH  = 8
) (
    input logic          clk,
    input logic          rst_n,
    ctv_unshift_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int MW = data_w * D;
    localparam logic [data_w-1:0] NULL_SHIFT = '1;
    localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);

    logic [data_w-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              out_valid_q, out_valid_d;
    logic [MW-1:0]     out_v_q, out_v_d;
    logic              out_null_q, out_null_d;
    logic              err_q, err_d;

    logic              fwd_ready, ret_ready, push, pop, head_null;
    logic [data_w-1:0] head, s_mod;
    logic [MW-1:0]     rot_v;

    // Ready depends only on registered state and out_ready, never on the valids.
    always_comb begin
        fwd_ready = (level_q != FULL_LEVEL);
        ret_ready = (level_q != '0) && (!out_valid_q || bus.out_ready);
        push      = bus.fwd_valid && fwd_ready;
        pop       = bus.ret_valid && ret_ready;
    end

    // Out-of-range shifts are folded back into 0..D-1 so they still rotate.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_null = (head == NULL_SHIFT);
        s_mod     = data_w'(int'(head) % D);
        rot_v     = '0;
        for (int j = 0; j < D; j++) begin
            for (int k = 0; k < D; k++) begin
                if (s_mod == data_w'(k)) begin
                    rot_v[j*data_w +: data_w] = bus.ret_ctv[((j - k + D) % D)*data_w +: data_w];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_v_d     = out_v_q;
        out_null_d  = out_null_q;
        err_d       = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if ((bus.fwd_shift != NULL_SHIFT) && (int'(bus.fwd_shift) >= D)) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_v_d     = head_null ? '0 : rot_v;
            out_null_d  = head_null;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_v_q     <= '0;
            out_null_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_v_q     <= out_v_d;
            out_null_q  <= out_null_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: entries are only read while level says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.fwd_shift;
        end
    end

    assign bus.fwd_ready = fwd_ready;
    assign bus.ret_ready = ret_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_null  = out_null_q;
    assign bus.level     = level_q;
    assign bus.err_shift = err_q;
endmodule

// File: tb/tb_ctv_unshift.sv
// tb/tb_ctv_unshift.sv - scoreboard bench for ctv_unshift with round-trip reference model
module tb_ctv_unshift;
    localparam int DW    = 8;
    localparam int D     = 5;
    localparam int DEPTH = 8;
    localparam int MW    = DW * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctv_unshift_if #(.data_w(DW), .D(D), .DEPTH(DEPTH)) bus ();
    ctv_unshift #(.data_w(DW), .D(D), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [$];
    logic [MW:0]   sb [$];
    bit            m_ov  = 1'b0;
    bit            m_err = 1'b0;

    localparam logic [MW-1:0] LANES = 40'h1413121110;
    localparam logic [MW-1:0] BASIC = 40'h1211101413;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Forward right-rotation by s lanes as a plain vector rotate.
    function automatic logic [MW-1:0] fwd_rot(input logic [MW-1:0] m, input int s);
        if (s == 0) return m;
        return (m >> (s*DW)) | (m << ((D-s)*DW));
    endfunction

    task automatic cycle(input bit fv, input logic [DW-1:0] fs, input bit rv,
                         input logic [MW-1:0] rc, input logic [MW-1:0] ev, input bit ordy);
        bit fr, rr;
        logic [DW-1:0] s;
        @(posedge clk); #1;
        chk("level", bus.level, mq.size());
        chk("out_valid", bus.out_valid, m_ov);
        chk("err_shift", bus.err_shift, m_err);
        bus.fwd_valid = fv;
        bus.fwd_shift = fs;
        bus.ret_valid = rv;
        bus.ret_ctv   = rc;
        bus.out_ready = ordy;
        #1;
        fr = (mq.size() != DEPTH);
        rr = (mq.size() != 0) && (!m_ov || ordy);
        chk("fwd_ready", bus.fwd_ready, fr);
        chk("ret_ready", bus.ret_ready, rr);
        if (rv && rr) begin
            s = mq.pop_front();
            if (s == 8'hFF) sb.push_back({1'b1, {MW{1'b0}}});
            else            sb.push_back({1'b0, ev});
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (fv && fr) begin
            mq.push_back(fs);
            if (fs != 8'hFF && int'(fs) >= D) m_err = 1'b1;
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, '0, 1'b0, '0, '0, ordy);
    endtask

    // Return beat built by forward-rotating orig by the head shift; expected result is orig.
    task automatic ret_beat(input logic [MW-1:0] orig, input bit ordy, input bit fv, input logic [DW-1:0] fs);
        logic [MW-1:0] rc;
        rc = orig;
        if (mq.size() != 0 && mq[0] != 8'hFF) rc = fwd_rot(orig, int'(mq[0]) % D);
        cycle(fv, fs, 1'b1, rc, orig, ordy);
    endtask

    function automatic logic [MW-1:0] rand_msg();
        return MW'({$urandom, $urandom});
    endfunction

    function automatic logic [DW-1:0] rand_shift();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 8'hFF;
        if (r == 1) return DW'($urandom_range(D, 254));
        return DW'($urandom_range(0, D-1));
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: output %0h present with empty scoreboard", bus.out_v);
            end else begin
                chk("out_beat", {bus.out_null, bus.out_v}, sb[0]);
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] full_list [8];
        full_list = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
        bus.fwd_valid = 1'b0;
        bus.fwd_shift = '0;
        bus.ret_valid = 1'b0;
        bus.ret_ctv   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_level", bus.level, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_v", bus.out_v, 0);
        chk("rst_out_null", bus.out_null, 0);
        chk("rst_err", bus.err_shift, 0);
        chk("rst_fwd_ready", bus.fwd_ready, 1);
        chk("rst_ret_ready", bus.ret_ready, 0);
        @(negedge clk) rst_n = 1'b1;

        cycle(1'b1, 8'd2, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, LANES, BASIC, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("basic_out_v", bus.out_v, BASIC);
        chk("basic_out_null", bus.out_null, 0);
        idle(1'b1);

        cycle(1'b1, 8'hFF, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, LANES, LANES, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("null_out_v", bus.out_v, 0);
        chk("null_out_null", bus.out_null, 1);
        idle(1'b1);

        cycle(1'b0, '0, 1'b1, rand_msg(), '0, 1'b1);

        for (int i = 0; i < 8; i++) cycle(1'b1, full_list[i], 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 8'd3, 1'b0, '0, '0, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 8; i++) ret_beat(rand_msg(), 1'b1, 1'b1, DW'($urandom_range(0, D-1)));
        for (int i = 0; i < 8; i++) ret_beat(rand_msg(), 1'b1, 1'b0, '0);
        idle(1'b1);

        cycle(1'b1, 8'd1, 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 8'd3, 1'b0, '0, '0, 1'b1);
        ret_beat(rand_msg(), 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) ret_beat(rand_msg(), 1'b0, 1'b0, '0);
        ret_beat(rand_msg(), 1'b1, 1'b0, '0);
        idle(1'b1);

        cycle(1'b1, 8'd7, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, LANES, BASIC, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("illegal_out_v", bus.out_v, BASIC);
        idle(1'b1);

        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(i), 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_err", bus.err_shift, 0);
        chk("arst_fwd_ready", bus.fwd_ready, 1);
        chk("arst_ret_ready", bus.ret_ready, 0);
        mq.delete();
        sb.delete();
        m_ov  = 1'b0;
        m_err = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                ret_beat(rand_msg(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rand_shift());
            else
                cycle($urandom_range(0, 3) != 0, rand_shift(), 1'b0, '0, '0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40 && (mq.size() != 0 || m_ov); i++) ret_beat(rand_msg(), 1'b1, 1'b0, '0);
        idle(1'b1);
        chk("drain_scoreboard", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
